load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 213 +++++++++++++++++++++
 tb/tb_load_store_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: sits between the memory pipeline stage and a req/gnt/rvalid
// data memory port. It checks size legality and alignment, builds byte lanes
// for stores, extends load data, and holds the pipeline until the access ends.
// Optional build macro: LSU_TIMEOUT_EN adds a 6-bit watchdog that aborts a
// request or response wait that lasts too long (TOUT state, timeout_o pulse).
module load_store_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        memrd_i,
  input  logic        memw_i,
  input  logic [2:0]  func3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o,
  output logic        timeout_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4,
    ST_TOUT = 3'd5
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic        accept_s;
  logic        bad_s;
  logic        tout_s;
  logic [2:0]  f3_r;
  logic [1:0]  off_r;

  // Illegal size code or address not aligned to the access size.
  function automatic logic access_bad(input logic we, input logic [2:0] f3,
                                      input logic [1:0] a);
    logic illegal;
    logic mis;
    if (we) begin
      illegal = f3[2] | (f3 == 3'b011);
    end else begin
      illegal = (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111);
    end
    mis = ((f3[1:0] == 2'b01) && a[0]) ||
          ((f3[1:0] == 2'b10) && (a != 2'b00));
    return illegal | mis;
  endfunction

  // Byte enables for the word addressed on the memory port.
  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data replicated so the enabled lanes carry the right bytes.
  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] d;
    case (f3[1:0])
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  // Select the addressed byte/half of the read word and sign/zero extend it.
  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rd[{a, 3'b000} +: 8];
    h = a[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'd0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'd0, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  assign accept_s = valid_i & (memrd_i | memw_i);
  // memw_i takes priority when both request lines are high
  assign bad_s    = access_bad(memw_i, func3_i, addr_i[1:0]);

`ifdef LSU_TIMEOUT_EN
  logic [5:0] cnt_r;
  logic       timeout_r;

  // The counter moves to 63 on the edge that leaves for TOUT.
  assign tout_s    = (cnt_r == 6'd62);
  assign timeout_o = timeout_r;

  // Watchdog: clear on entering REQ or WAIT, count every cycle spent there.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_r     <= 6'd0;
      timeout_r <= 1'b0;
    end else begin
      timeout_r <= (state_s == ST_TOUT);
      if ((state_s == ST_REQ && state_r != ST_REQ) ||
          (state_s == ST_WAIT && state_r != ST_WAIT)) begin
        cnt_r <= 6'd0;
      end else if (state_r == ST_REQ || state_r == ST_WAIT) begin
        cnt_r <= cnt_r + 6'd1;
      end else begin
        cnt_r <= 6'd0;
      end
    end
  end
`else
  assign tout_s    = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // Next-state logic and the combinational stall.
  always_comb begin
    state_s = state_r;
    stall_o = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          stall_o = 1'b1;
          if (bad_s) begin
            state_s = ST_ERR;
          end else begin
            state_s = ST_REQ;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        stall_o = 1'b1;
        if (dmem_gnt_i) begin
          state_s = dmem_we_o ? ST_DONE : ST_WAIT;
        end else if (tout_s) begin
          state_s = ST_TOUT;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        stall_o = 1'b1;
        if (dmem_rvalid_i) begin
          state_s = ST_DONE;
        end else if (tout_s) begin
          state_s = ST_TOUT;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      ST_ERR:  state_s = ST_IDLE;
      ST_TOUT: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register, registered status/port outputs, access latches and load data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= ST_IDLE;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= 32'd0;
      dmem_wdata_o <= 32'd0;
      dmem_be_o    <= 4'b0000;
      done_o       <= 1'b0;
      misalign_o   <= 1'b0;
      rdata_o      <= 32'd0;
      f3_r         <= 3'd0;
      off_r        <= 2'd0;
    end else begin
      state_r    <= state_s;
      dmem_req_o <= (state_s == ST_REQ);
      done_o     <= (state_s == ST_DONE) || (state_s == ST_ERR) || (state_s == ST_TOUT);
      misalign_o <= (state_s == ST_ERR);
      if (state_r == ST_IDLE && accept_s && !bad_s) begin
        f3_r         <= func3_i;
        off_r        <= addr_i[1:0];
        dmem_we_o    <= memw_i;
        dmem_addr_o  <= {addr_i[31:2], 2'b00};
        dmem_wdata_o <= lane_wdata(func3_i, wdata_i);
        dmem_be_o    <= lane_be(func3_i, addr_i[1:0]);
      end
      if (state_r == ST_WAIT && dmem_rvalid_i) begin
        rdata_o <= load_ext(f3_r, off_r, dmem_rdata_i);
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a table of single accesses with
// hand-computed lanes/extension results, plus multi-cycle corner sequences.
module tb_load_store_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i, memrd_i, memw_i;
  logic [2:0]  func3_i;
  logic [31:0] addr_i, wdata_i;
  logic        stall_o, done_o, misalign_o, timeout_o;
  logic [31:0] rdata_o;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;

  int checks = 0;
  int errors = 0;

  load_store_unit dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .memrd_i(memrd_i),
    .memw_i(memw_i), .func3_i(func3_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o),
    .misalign_o(misalign_o), .timeout_o(timeout_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i),
    .dmem_rdata_i(dmem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem;
    logic        bad;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    tick();
    valid_i = 1'b1; memrd_i = v.rd; memw_i = v.wr;
    func3_i = v.f3; addr_i = v.addr; wdata_i = v.wdata;
    #3 chk($sformatf("v%0d accept_stall", idx), {31'd0, stall_o}, 32'd1);
    tick();
    valid_i = 1'b0; memrd_i = 1'b0; memw_i = 1'b0;
    #3;
    if (v.bad) begin
      chk($sformatf("v%0d err_done", idx), {31'd0, done_o}, 32'd1);
      chk($sformatf("v%0d err_misalign", idx), {31'd0, misalign_o}, 32'd1);
      chk($sformatf("v%0d err_noreq", idx), {31'd0, dmem_req_o}, 32'd0);
      chk($sformatf("v%0d err_stall", idx), {31'd0, stall_o}, 32'd0);
      chk($sformatf("v%0d err_rdata", idx), rdata_o, v.exp_rdata);
    end else begin
      chk($sformatf("v%0d req", idx), {31'd0, dmem_req_o}, 32'd1);
      chk($sformatf("v%0d addr", idx), dmem_addr_o, v.exp_addr);
      chk($sformatf("v%0d we", idx), {31'd0, dmem_we_o}, {31'd0, v.wr});
      chk($sformatf("v%0d req_stall", idx), {31'd0, stall_o}, 32'd1);
      if (v.wr) begin
        chk($sformatf("v%0d wdata", idx), dmem_wdata_o, v.exp_wdata);
        chk($sformatf("v%0d be", idx), {28'd0, dmem_be_o}, {28'd0, v.exp_be});
      end
      dmem_gnt_i = 1'b1;
      tick();
      dmem_gnt_i = 1'b0;
      if (!v.wr) begin
        #3;
        chk($sformatf("v%0d wait_noreq", idx), {31'd0, dmem_req_o}, 32'd0);
        chk($sformatf("v%0d wait_stall", idx), {31'd0, stall_o}, 32'd1);
        chk($sformatf("v%0d wait_nodone", idx), {31'd0, done_o}, 32'd0);
        dmem_rvalid_i = 1'b1; dmem_rdata_i = v.mem;
        tick();
        dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'hDEAD_0000;
      end
      #3;
      chk($sformatf("v%0d done", idx), {31'd0, done_o}, 32'd1);
      chk($sformatf("v%0d done_nomis", idx), {31'd0, misalign_o}, 32'd0);
      chk($sformatf("v%0d done_stall", idx), {31'd0, stall_o}, 32'd0);
      chk($sformatf("v%0d rdata", idx), rdata_o, v.exp_rdata);
    end
    tick();
    #3 chk($sformatf("v%0d done_pulse_end", idx), {31'd0, done_o}, 32'd0);
  endtask

  initial begin
    int held;
    int seen;
    //           rd    wr    f3      addr        wdata          mem            bad   exp_addr    exp_wdata      be       exp_rdata
    vecs[0]  = '{1'b1, 1'b0, 3'b000, 32'h103,  32'h0,         32'h80FF_FF00, 1'b0, 32'h100, 32'h0,         4'h0,    32'hFFFF_FF80};
    vecs[1]  = '{1'b1, 1'b0, 3'b100, 32'h101,  32'h0,         32'h1234_5678, 1'b0, 32'h100, 32'h0,         4'h0,    32'h0000_0056};
    vecs[2]  = '{1'b1, 1'b0, 3'b001, 32'h022,  32'h0,         32'h8001_7FFF, 1'b0, 32'h020, 32'h0,         4'h0,    32'hFFFF_8001};
    vecs[3]  = '{1'b1, 1'b0, 3'b101, 32'h020,  32'h0,         32'h8001_F00D, 1'b0, 32'h020, 32'h0,         4'h0,    32'h0000_F00D};
    vecs[4]  = '{1'b1, 1'b0, 3'b010, 32'h040,  32'h0,         32'hDEAD_BEEF, 1'b0, 32'h040, 32'h0,         4'h0,    32'hDEAD_BEEF};
    vecs[5]  = '{1'b0, 1'b1, 3'b000, 32'h302,  32'h0000_00A5, 32'h0,         1'b0, 32'h300, 32'hA5A5_A5A5, 4'b0100, 32'hDEAD_BEEF};
    vecs[6]  = '{1'b1, 1'b1, 3'b010, 32'h044,  32'hCAFE_F00D, 32'h0,         1'b0, 32'h044, 32'hCAFE_F00D, 4'b1111, 32'hDEAD_BEEF};
    vecs[7]  = '{1'b0, 1'b1, 3'b001, 32'h200,  32'h1234_ABCD, 32'h0,         1'b0, 32'h200, 32'hABCD_ABCD, 4'b0011, 32'hDEAD_BEEF};
    vecs[8]  = '{1'b1, 1'b0, 3'b010, 32'h006,  32'h0,         32'h0,         1'b1, 32'h0,   32'h0,         4'h0,    32'hDEAD_BEEF};
    vecs[9]  = '{1'b1, 1'b0, 3'b001, 32'h011,  32'h0,         32'h0,         1'b1, 32'h0,   32'h0,         4'h0,    32'hDEAD_BEEF};
    vecs[10] = '{1'b1, 1'b0, 3'b011, 32'h000,  32'h0,         32'h0,         1'b1, 32'h0,   32'h0,         4'h0,    32'hDEAD_BEEF};
    vecs[11] = '{1'b0, 1'b1, 3'b100, 32'h000,  32'h0,         32'h0,         1'b1, 32'h0,   32'h0,         4'h0,    32'hDEAD_BEEF};
    vecs[12] = '{1'b0, 1'b1, 3'b001, 32'h201,  32'h0,         32'h0,         1'b1, 32'h0,   32'h0,         4'h0,    32'hDEAD_BEEF};
    vecs[13] = '{1'b1, 1'b0, 3'b000, 32'h100,  32'h0,         32'h0000_007F, 1'b0, 32'h100, 32'h0,         4'h0,    32'h0000_007F};
    vecs[14] = '{1'b1, 1'b0, 3'b000, 32'h102,  32'h0,         32'h0080_0000, 1'b0, 32'h100, 32'h0,         4'h0,    32'hFFFF_FF80};
    vecs[15] = '{1'b1, 1'b0, 3'b101, 32'h012,  32'h0,         32'hABCD_0000, 1'b0, 32'h010, 32'h0,         4'h0,    32'h0000_ABCD};
    vecs[16] = '{1'b1, 1'b0, 3'b110, 32'h000,  32'h0,         32'h0,         1'b1, 32'h0,   32'h0,         4'h0,    32'h0000_ABCD};

    rst_i = 1'b1; valid_i = 1'b0; memrd_i = 1'b0; memw_i = 1'b0;
    func3_i = 3'd0; addr_i = 32'd0; wdata_i = 32'd0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'd0;
    tick();
    tick();
    #3;
    chk("rst_req", {31'd0, dmem_req_o}, 32'd0);
    chk("rst_we", {31'd0, dmem_we_o}, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_misalign", {31'd0, misalign_o}, 32'd0);
    chk("rst_timeout", {31'd0, timeout_o}, 32'd0);
    chk("rst_addr", dmem_addr_o, 32'd0);
    chk("rst_wdata", dmem_wdata_o, 32'd0);
    chk("rst_be", {28'd0, dmem_be_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    rst_i = 1'b0;

    for (int i = 0; i < 17; i++) begin
      run_vec(i, vecs[i]);
    end

    // SH with grant held off for 4 cycles: request must stay stable
    tick();
    valid_i = 1'b1; memw_i = 1'b1; func3_i = 3'b001; addr_i = 32'h202; wdata_i = 32'h1234_ABCD;
    tick();
    valid_i = 1'b0; memw_i = 1'b0; addr_i = 32'hFFFF_FFFF; wdata_i = 32'h5555_5555;
    for (int i = 0; i < 5; i++) begin
      #3;
      chk($sformatf("sh_req%0d", i), {31'd0, dmem_req_o}, 32'd1);
      chk($sformatf("sh_addr%0d", i), dmem_addr_o, 32'h200);
      chk($sformatf("sh_wdata%0d", i), dmem_wdata_o, 32'hABCD_ABCD);
      chk($sformatf("sh_be%0d", i), {28'd0, dmem_be_o}, 32'hC);
      chk($sformatf("sh_stall%0d", i), {31'd0, stall_o}, 32'd1);
      chk($sformatf("sh_nodone%0d", i), {31'd0, done_o}, 32'd0);
      if (i == 4) dmem_gnt_i = 1'b1;
      tick();
    end
    dmem_gnt_i = 1'b0;
    #3;
    chk("sh_done", {31'd0, done_o}, 32'd1);
    chk("sh_req_drop", {31'd0, dmem_req_o}, 32'd0);
    chk("sh_stall_drop", {31'd0, stall_o}, 32'd0);
    chk("sh_rdata_kept", rdata_o, 32'h0000_ABCD);
    tick();

    // Stray grant/response while idle must do nothing
    dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hFFFF_FFFF;
    #3 chk("idle_noreq", {31'd0, dmem_req_o}, 32'd0);
    tick();
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    #3;
    chk("idle_nodone", {31'd0, done_o}, 32'd0);
    chk("idle_rdata", rdata_o, 32'h0000_ABCD);

    // LHU with reset asserted while waiting for the response
    tick();
    valid_i = 1'b1; memrd_i = 1'b1; func3_i = 3'b101; addr_i = 32'h010;
    tick();
    valid_i = 1'b0; memrd_i = 1'b0; dmem_gnt_i = 1'b1;
    #3 chk("rstw_req", {31'd0, dmem_req_o}, 32'd1);
    tick();
    dmem_gnt_i = 1'b0; rst_i = 1'b1;
    #3 chk("rstw_wait_stall", {31'd0, stall_o}, 32'd1);
    tick();
    rst_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h0000_FFFF;
    #3;
    chk("rstw_stall", {31'd0, stall_o}, 32'd0);
    chk("rstw_done0", {31'd0, done_o}, 32'd0);
    chk("rstw_rdata0", rdata_o, 32'd0);
    tick();
    dmem_rvalid_i = 1'b0;
    #3;
    chk("rstw_done1", {31'd0, done_o}, 32'd0);
    chk("rstw_rdata1", rdata_o, 32'd0);
    tick();
    #3 chk("rstw_done2", {31'd0, done_o}, 32'd0);

    // Store whose grant never comes
    tick();
    valid_i = 1'b1; memw_i = 1'b1; func3_i = 3'b010; addr_i = 32'h080; wdata_i = 32'h1;
    tick();
    valid_i = 1'b0; memw_i = 1'b0;
`ifdef LSU_TIMEOUT_EN
    seen = -1;
    for (int n = 0; n < 80; n++) begin
      #3;
      if (timeout_o && seen < 0) begin
        seen = n;
        chk("tout_done", {31'd0, done_o}, 32'd1);
        chk("tout_req_drop", {31'd0, dmem_req_o}, 32'd0);
      end
      tick();
    end
    chk("tout_cycle", seen, 32'd63);
`else
    held = 0;
    seen = 0;
    for (int n = 0; n < 70; n++) begin
      #3;
      if (dmem_req_o && stall_o && !timeout_o && !done_o) held++;
      tick();
    end
    chk("notout_req_held", held, 32'd70);
    #3;
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    #3 chk("notout_done", {31'd0, done_o}, 32'd1);
    chk("notout_timeout", {31'd0, timeout_o}, {31'd0, 1'b0});
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
